// File: rtl/accum_writeback_engine.sv
// rtl/accum_writeback_engine.sv - drains an msize x nsize accumulator tile to a 128-bit memory interface
//
// Purpose: walks the result tile row by row, one beat per column group
// (accumulator buffer), popping each buffer as its beat is accepted.
// Partial last column groups are written with reduced byte strobes.
//
// Optional feature macro: WB_PERF_CNT_EN enables the stall_cycles counter;
// when undefined, stall_cycles is tied to zero.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   start, tile_C_addr, row_stride,
//   msize, nsize                      tile request and geometry
//   buffer_empty, accum_o_data,
//   rd_result                         per-buffer FWFT heads and one-hot pop
//   interface_en/rdwr/ready/addr/
//   wr_data/wr_strb                   memory write beat handshake
//   busy, done                        tile in flight / completion pulse
//   stall_cycles                      stall performance counter
module accum_writeback_engine #(
    parameter int NUM_BUF = 4,
    parameter int DATA_W  = 128,
    parameter int ELEM_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int SIZE_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         tile_C_addr,
    input  logic [ADDR_W-1:0]         row_stride,
    input  logic [SIZE_W-1:0]         msize,
    input  logic [SIZE_W-1:0]         nsize,
    input  logic [NUM_BUF-1:0]        buffer_empty,
    input  logic [NUM_BUF*DATA_W-1:0] accum_o_data,
    output logic [NUM_BUF-1:0]        rd_result,
    output logic                      interface_en,
    output logic                      interface_rdwr,
    input  logic                      interface_ready,
    output logic [ADDR_W-1:0]         interface_addr,
    output logic [DATA_W-1:0]         interface_wr_data,
    output logic [DATA_W/8-1:0]       interface_wr_strb,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               stall_cycles
);

    localparam int COLS  = DATA_W / ELEM_W;
    localparam int MAX_N = NUM_BUF * COLS;
    localparam int BYTES = DATA_W / 8;
    localparam int EB    = ELEM_W / 8;
    localparam int BW    = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam int CW    = $clog2(COLS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [SIZE_W-1:0]   msize_q, msize_d;
    logic [SIZE_W-1:0]   r_q, r_d;
    logic [BW-1:0]       nbm1_q, nbm1_d;
    logic [BW-1:0]       b_q, b_d;
    logic [CW-1:0]       lastc_q, lastc_d;
    // Degenerate tiles spend one extra cycle in DONE so completion lands in
    // cycle 2, the same latency as a single-beat tile.
    logic                skip_q, skip_d;

    logic cur_empty;
    logic hs;

    assign cur_empty      = buffer_empty[b_q];
    assign interface_en   = (state_q == RUN) && !cur_empty;
    assign hs             = interface_en && interface_ready;
    assign rd_result      = hs ? (NUM_BUF'(1) << b_q) : '0;
    assign interface_rdwr = 1'b1;

    always_comb begin
        int n_i;
        int nb_i;
        int lc_i;
        state_d    = state_q;
        row_base_d = row_base_q;
        stride_d   = stride_q;
        msize_d    = msize_q;
        r_d        = r_q;
        nbm1_d     = nbm1_q;
        b_d        = b_q;
        lastc_d    = lastc_q;
        skip_d     = skip_q;
        busy       = 1'b0;
        done       = 1'b0;

        n_i = int'(nsize);
        if (n_i > MAX_N) n_i = MAX_N;
        nb_i = (n_i + COLS - 1) / COLS;
        lc_i = n_i - (nb_i - 1) * COLS;

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_base_d = tile_C_addr;
                    stride_d   = row_stride;
                    msize_d    = msize;
                    nbm1_d     = BW'(nb_i - 1);
                    lastc_d    = CW'(lc_i);
                    r_d        = '0;
                    b_d        = '0;
                    if (msize == '0 || n_i == 0) begin
                        state_d = DONE;
                        skip_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (hs) begin
                    if (b_q == nbm1_q) begin
                        b_d        = '0;
                        r_d        = r_q + SIZE_W'(1);
                        row_base_d = row_base_q + stride_q;
                        if (r_q == msize_q - SIZE_W'(1)) state_d = DONE;
                    end else begin
                        b_d = b_q + BW'(1);
                    end
                end
            end
            DONE: begin
                if (skip_q) begin
                    busy   = 1'b1;
                    skip_d = 1'b0;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat fields are forced to zero outside RUN so idle/reset outputs are quiet.
    always_comb begin
        interface_addr    = '0;
        interface_wr_data = '0;
        interface_wr_strb = '0;
        if (state_q == RUN) begin
            interface_addr    = row_base_q + ADDR_W'(b_q) * ADDR_W'(BYTES);
            interface_wr_data = accum_o_data[b_q*DATA_W +: DATA_W];
            if (b_q == nbm1_q) begin
                for (int j = 0; j < BYTES; j++) begin
                    interface_wr_strb[j] = (j < int'(lastc_q) * EB);
                end
            end else begin
                interface_wr_strb = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            row_base_q <= '0;
            stride_q   <= '0;
            msize_q    <= '0;
            r_q        <= '0;
            nbm1_q     <= '0;
            b_q        <= '0;
            lastc_q    <= '0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            stride_q   <= stride_d;
            msize_q    <= msize_d;
            r_q        <= r_d;
            nbm1_q     <= nbm1_d;
            b_q        <= b_d;
            lastc_q    <= lastc_d;
            skip_q     <= skip_d;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (state_q == RUN && (cur_empty || (interface_en && !interface_ready))
                     && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
